// File: rtl/vdp_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vdp_vram_arbiter
//  Purpose  : Single-port VRAM arbiter for four requesters (screen fetch,
//             sprite fetch, CPU port, command engine). Only one access is in
//             flight at a time. Reads are guarded by a timeout that returns
//             all-ones and sets a sticky error flag.
//  Options  : VRAM_ARB_ROUND_ROBIN_EN - round-robin between cpu and cmd
//             (otherwise fixed cpu > cmd).
//  Revision : 1.0 - initial release
// ============================================================================
module vdp_vram_arbiter #(
    // Cycles spent in WAIT_RD before a read is forced to complete (4..255)
    parameter int unsigned READ_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        scr_valid,
    input  logic        scr_write,
    input  logic [16:0] scr_address,
    input  logic [7:0]  scr_wdata,
    output logic        scr_ready,
    output logic [31:0] scr_rdata,
    output logic        scr_rdata_en,

    input  logic        spr_valid,
    input  logic        spr_write,
    input  logic [16:0] spr_address,
    input  logic [7:0]  spr_wdata,
    output logic        spr_ready,
    output logic [31:0] spr_rdata,
    output logic        spr_rdata_en,

    input  logic        cpu_valid,
    input  logic        cpu_write,
    input  logic [16:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rdata_en,

    input  logic        cmd_valid,
    input  logic        cmd_write,
    input  logic [16:0] cmd_address,
    input  logic [7:0]  cmd_wdata,
    output logic        cmd_ready,
    output logic [31:0] cmd_rdata,
    output logic        cmd_rdata_en,

    output logic [16:0] vram_address,
    output logic        vram_write,
    output logic        vram_valid,
    output logic [7:0]  vram_wdata,
    input  logic [31:0] vram_rdata,
    input  logic        vram_rdata_en,

    output logic        arb_error
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    // Requester indices; also the bit position in the packed request vectors
    localparam logic [1:0] OWN_SCR = 2'd0;
    localparam logic [1:0] OWN_SPR = 2'd1;
    localparam logic [1:0] OWN_CPU = 2'd2;
    localparam logic [1:0] OWN_CMD = 2'd3;

    // Counter value seen in the last permitted WAIT_RD cycle
    localparam logic [7:0] TIMEOUT_LAST = 8'(READ_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [16:0]       addr_q, addr_d;
    logic              write_q, write_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0][31:0]  rdata_q, rdata_d;
    logic [3:0]        rdata_en_q, rdata_en_d;
    logic              err_q, err_d;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
    // 1 = cmd wins the next cpu/cmd tie, 0 = cpu wins it
    logic              rr_q, rr_d;
`endif

    logic [3:0]        req_valid;
    logic [3:0]        req_write;
    logic [3:0][16:0]  req_addr;
    logic [3:0][7:0]   req_wdata;
    logic [1:0]        winner;

    assign req_valid = {cmd_valid, cpu_valid, spr_valid, scr_valid};
    assign req_write = {cmd_write, cpu_write, spr_write, scr_write};
    assign req_addr  = {cmd_address, cpu_address, spr_address, scr_address};
    assign req_wdata = {cmd_wdata, cpu_wdata, spr_wdata, scr_wdata};

    // Priority select: scr, then spr, then the cpu/cmd tier
    always_comb begin
        winner = OWN_CMD;
        if (scr_valid) begin
            winner = OWN_SCR;
        end else if (spr_valid) begin
            winner = OWN_SPR;
        end else if (cpu_valid && cmd_valid) begin
`ifdef VRAM_ARB_ROUND_ROBIN_EN
            winner = rr_q ? OWN_CMD : OWN_CPU;
`else
            winner = OWN_CPU;
`endif
        end else if (cpu_valid) begin
            winner = OWN_CPU;
        end
    end

    // Next-state and datapath update for the IDLE / ISSUE / WAIT_RD sequence
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rdata_en_d = 4'b0000;
        err_d      = err_q;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
        rr_d       = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    owner_d = winner;
                    addr_d  = req_addr[winner];
                    write_d = req_write[winner];
                    wdata_d = req_wdata[winner];
                    state_d = ST_ISSUE;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
                    // The tier member just served loses the next tie
                    if (winner == OWN_CPU) begin
                        rr_d = 1'b1;
                    end else if (winner == OWN_CMD) begin
                        rr_d = 1'b0;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = write_q ? ST_IDLE : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (vram_rdata_en) begin
                    rdata_d[owner_q]    = vram_rdata;
                    rdata_en_d[owner_q] = 1'b1;
                    state_d             = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Memory never answered: hand back all-ones and flag it
                    rdata_d[owner_q]    = 32'hFFFF_FFFF;
                    rdata_en_d[owner_q] = 1'b1;
                    err_d               = 1'b1;
                    state_d             = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_SCR;
            addr_q     <= 17'd0;
            write_q    <= 1'b0;
            wdata_q    <= 8'd0;
            cnt_q      <= 8'd0;
            rdata_q    <= '0;
            rdata_en_q <= 4'b0000;
            err_q      <= 1'b0;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rdata_en_q <= rdata_en_d;
            err_q      <= err_d;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
            rr_q       <= rr_d;
`endif
        end
    end

    logic [3:0] ready_vec;

    // Accept pulse goes to the owner only while the command is on the bus
    always_comb begin
        ready_vec = 4'b0000;
        if (state_q == ST_ISSUE) begin
            ready_vec[owner_q] = 1'b1;
        end
    end

    assign vram_valid   = (state_q == ST_ISSUE);
    assign vram_address = addr_q;
    assign vram_write   = write_q;
    assign vram_wdata   = wdata_q;
    assign arb_error    = err_q;

    assign scr_ready    = ready_vec[OWN_SCR];
    assign spr_ready    = ready_vec[OWN_SPR];
    assign cpu_ready    = ready_vec[OWN_CPU];
    assign cmd_ready    = ready_vec[OWN_CMD];

    assign scr_rdata    = rdata_q[OWN_SCR];
    assign spr_rdata    = rdata_q[OWN_SPR];
    assign cpu_rdata    = rdata_q[OWN_CPU];
    assign cmd_rdata    = rdata_q[OWN_CMD];

    assign scr_rdata_en = rdata_en_q[OWN_SCR];
    assign spr_rdata_en = rdata_en_q[OWN_SPR];
    assign cpu_rdata_en = rdata_en_q[OWN_CPU];
    assign cmd_rdata_en = rdata_en_q[OWN_CMD];

endmodule
`default_nettype wire

// File: doc/vdp_vram_arbiter.md
VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

Interface
REQ-001 Parameter READ_TIMEOUT, default 15, max cycles in WAIT_RD before forced completion (range 4..255).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 <p> denotes one of four requester prefixes: scr (screen fetch), spr (sprite fetch), cpu (CPU port), cmd (command engine); REQ-005..REQ-011 exist once per prefix.
REQ-005 <p>_valid  input  1  request pending; held high until <p>_ready.
REQ-006 <p>_write  input  1  1 = write, 0 = read; stable while <p>_valid.
REQ-007 <p>_address  input  17  byte address; stable while <p>_valid.
REQ-008 <p>_wdata  input  8  write byte; stable while <p>_valid.
REQ-009 <p>_ready  output  1  one-cycle accept pulse.
REQ-010 <p>_rdata  output  32  read word; holds last value delivered to this requester.
REQ-011 <p>_rdata_en  output  1  one-cycle pulse, <p>_rdata valid.
REQ-012 vram_address  output  17  to VRAM; bits [1:0] ignored by memory on reads.
REQ-013 vram_write / vram_valid  output  1 each  command strobe; vram_valid high exactly one cycle per access.
REQ-014 vram_wdata  output  8  write byte.
REQ-015 vram_rdata  input  32  read word, sampled when vram_rdata_en high.
REQ-016 vram_rdata_en  input  1  read data valid; may stay high more than one cycle.
REQ-017 arb_error  output  1  sticky flag, set on any read timeout.

Function
REQ-018 States: IDLE, ISSUE, WAIT_RD.
REQ-019 IDLE: if any <p>_valid, select winner, register vram_address/write/wdata from winner, record owner, go ISSUE; else stay.
REQ-020 Priority: scr > spr > {cpu, cmd} tier (tier resolution per REQ-031/032).
REQ-021 ISSUE (one cycle): vram_valid=1 and owner's <p>_ready=1; next state WAIT_RD if read, else IDLE.
REQ-022 No arbitration in ISSUE; a requester's valid still high in the ISSUE cycle is not re-granted.
REQ-023 Write throughput: one access per 2 cycles; read occupancy: 2 cycles + memory latency.
REQ-024 WAIT_RD: on first cycle with vram_rdata_en=1, register vram_rdata into owner's <p>_rdata, pulse owner's <p>_rdata_en next cycle, go IDLE; arbitration resumes in that same IDLE cycle.
REQ-025 Only one access outstanding; vram_rdata_en seen in IDLE or ISSUE is ignored; a continuously high vram_rdata_en completes at most one read.
REQ-026 Timeout counter 8-bit, cleared on entering WAIT_RD; on reaching READ_TIMEOUT without vram_rdata_en: owner <p>_rdata=32'hFFFFFFFF, <p>_rdata_en pulse, arb_error=1, go IDLE.
REQ-027 Non-owner <p>_rdata, <p>_rdata_en and <p>_ready stay unchanged/low.
REQ-028 Outside ISSUE, vram_valid=0; vram_address/write/wdata hold last issued values.

Reset
REQ-029 On reset: state IDLE, all <p>_ready, <p>_rdata_en, vram_valid, vram_write, arb_error = 0; vram_address, vram_wdata, all <p>_rdata = 0; round-robin pointer favours cpu.
REQ-030 Reset during ISSUE or WAIT_RD abandons the access with no <p>_ready or <p>_rdata_en pulse; the first cycle after reset is IDLE.

Configuration
REQ-031 With VRAM_ARB_ROUND_ROBIN_EN defined: cpu/cmd tie resolved round-robin; the tier member granted last loses the next tie; pointer updates only on a tier grant.
REQ-032 Without VRAM_ARB_ROUND_ROBIN_EN: fixed cpu > cmd; no pointer register.

Verification
REQ-033 cpu write addr 17'h00003 data 8'hA5 alone -> vram_valid one cycle, vram_write=1, addr 17'h00003, wdata 8'hA5, cpu_ready in same cycle.
REQ-034 scr, spr, cpu reads asserted same cycle, memory latency 4 -> grant order scr, spr, cpu; each <p>_rdata_en carries correct word; no overlap of vram_valid with outstanding read.
REQ-035 cpu and cmd writes continuously valid, macro defined -> grants alternate cpu, cmd, cpu, cmd; macro undefined -> cpu until it drops valid.
REQ-036 Read with memory never returning vram_rdata_en, READ_TIMEOUT=15 -> owner rdata_en after 15 WAIT_RD cycles, rdata 32'hFFFFFFFF, arb_error=1 until reset.
REQ-037 reset asserted in WAIT_RD, late vram_rdata_en after release -> no <p>_rdata_en pulse; next request served normally.
